chunk_comparator: RTL
=====================

# chunk_comparator

Multi-cycle, parametrised magnitude comparator. Compares two N-bit operands W bits per cycle, most significant chunk first, with early termination. Supports unsigned and two's-complement signed compare, selected per operation. Produces registered one-hot L/E/G flags with a start/busy/done handshake. Intended for wide operands (64+ bits) where a single-cycle compare breaks timing; replaces the combinational N=4 comparator wherever width or timing demands it.

## Interface

Parameters:
- N, 32, operand width in bits; N must be an integer multiple of W.
- W, 8, chunk width compared per cycle; W=N gives a one-chunk compare.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = unsigned, 1 = signed two's complement; captured with start.
- clr  input  1  synchronous abort of an operation in progress.
- A  input  N  operand A; captured with start.
- B  input  N  operand B; captured with start.
- busy  output  1  high while in BUSY.
- done  output  1  one-cycle pulse when new L/E/G are valid.
- L  output  1  A < B.
- E  output  1  A == B.
- G  output  1  A > B.

## Operation

- K = N/W chunks. States: IDLE, BUSY. Internal registers: a_sh, b_sh (N bits each), chunk index idx (clog2(K) bits, minimum 1 bit).
- IDLE, start=1 at an edge: capture A, B → a_sh, b_sh. If mode=1, invert bit N-1 of both captured operands (offset-binary mapping, so an unsigned compare yields the signed order). Set idx=0 and go to BUSY.
- IDLE, start=0: remain in IDLE.
- BUSY, clr=0, each edge: compare ca = a_sh[N-1:N-W] with cb = b_sh[N-1:N-W], unsigned.
  - ca < cb: L,E,G ← 1,0,0; done ← 1; go to IDLE.
  - ca > cb: L,E,G ← 0,0,1; done ← 1; go to IDLE.
  - ca == cb and idx == K-1: L,E,G ← 0,1,0; done ← 1; go to IDLE.
  - otherwise: shift a_sh and b_sh left by W; idx ← idx+1; stay in BUSY.
- BUSY, clr=1: go to IDLE; done stays 0; L/E/G unchanged; the compare on that edge is discarded. clr in IDLE has no effect.
- start while BUSY is ignored, including on the edge that completes the operation. mode, A and B are ignored outside the capture edge.
- L/E/G are held from one result to the next. A new start does not clear them. After the first result they are exactly one-hot.
- Reset (any time, including mid-operation): state=IDLE, busy=0, done=0, L=E=G=0, a_sh=b_sh=0, idx=0.

## Timing

- Edge e0 captures start. busy=1 from e0 until the deciding edge.
- The chunk decided at edge e_j (j = 1..K) updates L/E/G, sets done=1 and clears busy on that same edge.
- Latency from start capture to done: j cycles, where j is the index of the first differing chunk counted from the MSB, or K if the operands are equal.
- done is high for exactly one cycle. It is cleared on the next edge unless a new result lands.
- Back-to-back: start may be asserted in the cycle where done=1 (state is IDLE) and is accepted. Minimum issue interval is therefore j+1 cycles: 2 cycles for a top-chunk decision, K+1 for equal operands.
- No combinational path from any input to any output.

## Test plan

- N=32, W=8, mode=0, A=B=32'h1234_5678 → done 4 cycles after start; L,E,G = 0,1,0; busy high for 4 cycles.
- mode=0, A=32'h8000_0000, B=32'h7FFF_FFFF → G=1, done 1 cycle after start (early termination). Same operands with mode=1 → L=1, latency 1.
- mode=1, A=32'hFFFF_FFFF (−1), B=32'h0000_0001 → L=1. mode=0 with the same operands → G=1. A=32'h0000_00FF, B=32'h0000_00FE, mode=0 → G=1 with latency 4.
- start pulsed while busy with different operands → ignored, first result unchanged. start asserted in the done cycle → accepted, second result correct.
- clr at cycle 2 of an equal-operand compare → busy drops, no done pulse, L/E/G keep their previous values. A new start then completes normally.
- rst asserted asynchronously mid-compare → busy, done, L, E, G all 0 immediately. After release, a fresh compare of 5 vs 5 gives E=1.

Source files
------------

// File: rtl/chunk_comparator.sv
// chunk_comparator
//   Multi-cycle magnitude comparator. It compares two N-bit operands W bits per
//   cycle, starting with the most significant chunk, and stops at the first chunk
//   that differs. The compare is either unsigned or two's-complement signed, chosen
//   for each operation.
//
// Parameters
//   N  operand width; must be an integer multiple of W.
//   W  chunk width compared per cycle. W == N gives a single-chunk compare.
//
// Ports
//   clk    rising-edge clock
//   rst    asynchronous, active-high reset
//   start  request; sampled only while idle
//   mode   0 = unsigned, 1 = signed; captured together with start
//   clr    synchronous abort of an operation in progress
//   A, B   operands; captured together with start
//   busy   high while a compare is in progress
//   done   one-cycle pulse when a new L/E/G result lands
//   L/E/G  registered A<B, A==B and A>B flags. They hold their value until the
//          next result.
module chunk_comparator #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic         clr,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         L,
  output logic         E,
  output logic         G
);

  localparam int K  = N / W;
  localparam int IW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);
  // Flipping the sign bit maps two's complement onto offset binary. After that,
  // an unsigned compare gives the signed ordering.
  localparam logic [N-1:0] SIGN_FLIP = {1'b1, {(N-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t         state;
  logic [N-1:0]   a_sh;
  logic [N-1:0]   b_sh;
  logic [IW-1:0]  idx;

  logic [W-1:0]   ca;
  logic [W-1:0]   cb;

  // The chunk under test is always the top W bits. The operand registers shift
  // left after every equal chunk.
  assign ca = a_sh[N-1 -: W];
  assign cb = b_sh[N-1 -: W];

  // Unsigned compare of one chunk.
  // Result encoding: 2'b10 = less, 2'b01 = greater, 2'b00 = equal.
  function automatic logic [1:0] chunk_cmp(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [1:0] r;
    r = 2'b00;
    if (x < y)      r = 2'b10;
    else if (x > y) r = 2'b01;
    return r;
  endfunction

  logic [1:0] cmp;
  assign cmp = chunk_cmp(ca, cb);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      L     <= 1'b0;
      E     <= 1'b0;
      G     <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      idx   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= mode ? (A ^ SIGN_FLIP) : A;
            b_sh  <= mode ? (B ^ SIGN_FLIP) : B;
            idx   <= '0;
            busy  <= 1'b1;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (clr) begin
            // Abort: drop the compare on this edge and keep the previous flags.
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cmp != 2'b00 || idx == LAST_IDX) begin
            L     <= cmp[1];
            G     <= cmp[0];
            E     <= (cmp == 2'b00);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            a_sh <= a_sh << W;
            b_sh <= b_sh << W;
            idx  <= idx + 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
